// File: rtl/regfile_dump_unit.sv
// Debug dump reader: walks register-file indices through the rs port and
// streams (index, value) pairs over a valid/ready handshake.
module regfile_dump_unit #(
  parameter int NUM_REGS   = 32,
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_abort,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [DATA_W-1:0] i_rd_data,
  output logic              o_dump_valid,
  input  logic              i_dump_ready,
  output logic [ADDR_W-1:0] o_dump_idx,
  output logic [DATA_W-1:0] o_dump_data,
  output logic              o_busy,
  output logic              o_done
);

  localparam int WAIT_W = (RD_LATENCY > 0) ? $clog2(RD_LATENCY + 1) : 1;
  localparam logic [WAIT_W-1:0] LAT  = WAIT_W'(RD_LATENCY);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_VALID, S_DONE} state_t;

  state_t              r_state, w_state;
  logic [ADDR_W-1:0]   r_idx,   w_idx;
  logic [WAIT_W-1:0]   r_wait,  w_wait;
  logic                r_valid, w_valid;
  logic [ADDR_W-1:0]   r_didx,  w_didx;
  logic [DATA_W-1:0]   r_ddata, w_ddata;
  logic                r_busy,  w_busy;
  logic                r_done,  w_done;
  logic                w_hs;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_wait  <= '0;
      r_valid <= 1'b0;
      r_didx  <= '0;
      r_ddata <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_idx   <= w_idx;
      r_wait  <= w_wait;
      r_valid <= w_valid;
      r_didx  <= w_didx;
      r_ddata <= w_ddata;
      r_busy  <= w_busy;
      r_done  <= w_done;
    end
  end

  always_comb begin
    w_state = r_state;
    w_idx   = r_idx;
    w_wait  = r_wait;
    w_valid = r_valid;
    w_didx  = r_didx;
    w_ddata = r_ddata;
    w_done  = 1'b0;
    w_hs    = r_valid & i_dump_ready;
    case (r_state)
      S_IDLE: begin
        if (i_start && !i_abort) begin
          w_state = S_RD;
          w_idx   = '0;
          w_wait  = '0;
        end
      end
      S_RD: begin
        if (i_abort) begin
          w_state = S_IDLE;
        end else if (r_wait == LAT) begin
          w_ddata = i_rd_data;
          w_didx  = r_idx;
          w_valid = 1'b1;
          w_state = S_VALID;
        end else begin
          w_wait = r_wait + WAIT_W'(1);
        end
      end
      S_VALID: begin
        // abort wins over a coinciding handshake: the pair is not consumed
        if (i_abort) begin
          w_state = S_IDLE;
          w_valid = 1'b0;
        end else if (w_hs) begin
          w_valid = 1'b0;
          if (r_idx == LAST) begin
            w_state = S_DONE;
          end else begin
            w_idx   = r_idx + ADDR_W'(1);
            w_wait  = '0;
            w_state = S_RD;
          end
        end
      end
      S_DONE: begin
        // two cycles here: the first raises done, the second returns to idle
        if (i_abort)      w_state = S_IDLE;
        else if (!r_done) w_done  = 1'b1;
        else              w_state = S_IDLE;
      end
      default: w_state = S_IDLE;
    endcase
    w_busy = (w_state != S_IDLE);
  end

  assign o_rd_addr    = r_idx;
  assign o_dump_valid = r_valid;
  assign o_dump_idx   = r_didx;
  assign o_dump_data  = r_ddata;
  assign o_busy       = r_busy;
  assign o_done       = r_done;

endmodule
